if_id_fetch: RTL

Instruction-fetch back half of the MIPS pipeline: it holds the 256-byte instruction memory addressed by the 8-bit PC, loads that memory byte-serially from the debug/loader path, and registers the fetched instruction and PC+4 into the IF/ID pipeline register consumed by the ID stage. It sits directly downstream of the PC register and upstream of decode.

---
 rtl/if_id_fetch.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/if_id_fetch.sv
// IF back half: byte-serial loaded instruction memory
// plus the IF/ID pipeline register.
module if_id_fetch #(
  parameter int unsigned MEM_BYTES = 256,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [7:0]  pc,
  input  logic        stall,
  input  logic        flush,
  input  logic        write_en,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  output logic [31:0] instr_id,
  output logic [7:0]  pc4_id,
  output logic        valid_id,
  output logic [6:0]  load_words,
  output logic        load_busy
);

  localparam int unsigned WORDS = MEM_BYTES / 4;

  typedef enum logic {
    S_IDLE,
    S_LOAD
  } state_e;

  logic [31:0] mem_q [WORDS];

  state_e      state_q, state_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [5:0]  waddr_q, waddr_d;
  logic [23:0] asm_q, asm_d;
  logic [6:0]  lw_q, lw_d;
  logic        mem_we;
  logic [31:0] mem_wdata;

  logic [31:0] instr_q, instr_d;
  logic [7:0]  pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] fetch_word;

  assign fetch_word = mem_q[pc[7:2]];

  // Loader FSM: assemble big-endian bytes, write on the 4th.
  always_comb begin
    state_d   = state_q;
    bidx_d    = bidx_q;
    waddr_d   = waddr_q;
    asm_d     = asm_q;
    lw_d      = lw_q;
    mem_we    = 1'b0;
    mem_wdata = {asm_q, load_byte};
    unique case (state_q)
      S_IDLE: begin
        if (write_en) begin
          state_d = S_LOAD;
          bidx_d  = 2'd0;
          waddr_d = 6'd0;
          lw_d    = 7'd0;
        end
      end
      S_LOAD: begin
        if (!write_en) begin
          state_d = S_IDLE;
          bidx_d  = 2'd0;
        end else if (load_valid) begin
          bidx_d = bidx_q + 2'd1;
          unique case (bidx_q)
            2'd0: asm_d[23:16] = load_byte;
            2'd1: asm_d[15:8]  = load_byte;
            2'd2: asm_d[7:0]   = load_byte;
            2'd3: begin
              mem_we  = 1'b1;
              waddr_d = waddr_q + 6'd1;
              if (lw_q != 7'd64)
                lw_d = lw_q + 7'd1;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Loader state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      bidx_q  <= 2'd0;
      waddr_q <= 6'd0;
      asm_q   <= 24'd0;
      lw_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      waddr_q <= waddr_d;
      asm_q   <= asm_d;
      lw_q    <= lw_d;
    end
  end

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[waddr_q] <= mem_wdata;
  end

  // IF/ID next value: loader > flush > stall > clk_en.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (write_en || state_q == S_LOAD) begin
      instr_d = NOP_WORD;
      pc4_d   = 8'd0;
      valid_d = 1'b0;
    end else if (flush) begin
      instr_d = NOP_WORD;
      pc4_d   = 8'd0;
      valid_d = 1'b0;
    end else if (stall) begin
      instr_d = instr_q;
    end else if (clk_en) begin
      instr_d = fetch_word;
      pc4_d   = pc + 8'd4;
      valid_d = 1'b1;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP_WORD;
      pc4_q   <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_id   = instr_q;
  assign pc4_id     = pc4_q;
  assign valid_id   = valid_q;
  assign load_words = lw_q;
  assign load_busy  = (state_q == S_LOAD);

endmodule
